intersection_lamp_driver: RTL and testbench

//  Downstream stage of the HPS gpio_0 output port. Decodes the 16-bit lamp command word written
//  by QNX into per-approach red/amber/green drives for a 4-way intersection (N,E,S,W).

---
 rtl/intersection_pkg.sv | 55 +++++
 rtl/intersection_lamp_driver_if.sv | 25 ++
 rtl/lamp_flash_timer.sv | 36 +++
 rtl/intersection_lamp_driver.sv | 138 +++++++++++++
 tb/tb_intersection_lamp_driver.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection lamp driver: light codes,
// lamp bit positions, FSM states and fault codes.
package intersection_pkg;

    localparam logic [2:0] CODE_DARK    = 3'b000;
    localparam logic [2:0] CODE_RED     = 3'b001;
    localparam logic [2:0] CODE_AMBER   = 3'b010;
    localparam logic [2:0] CODE_GREEN   = 3'b011;
    localparam logic [2:0] CODE_FL_AMB  = 3'b100;
    localparam logic [2:0] CODE_FL_RED  = 3'b101;

    localparam int LAMP_GRN = 0;
    localparam int LAMP_AMB = 1;
    localparam int LAMP_RED = 2;

    localparam logic [11:0] ALL_RED   = 12'h924;
    localparam logic [11:0] ALL_AMBER = 12'h492;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_WDOG     = 2'b01;
    localparam logic [1:0] FC_CONFLICT = 2'b10;
    localparam logic [1:0] FC_BOTH     = 2'b11;

    typedef enum logic [1:0] {
        ST_STARTUP  = 2'b00,
        ST_RUN      = 2'b01,
        ST_FAILSAFE = 2'b10
    } state_e;

    // Returns {red, amber, green} for one approach.
    function automatic logic [2:0] decode_code(
        input logic [2:0] code,
        input logic       phase
    );
        logic [2:0] l;
        l = 3'b000;
        unique case (code)
            CODE_DARK:   l = 3'b000;
            CODE_RED:    l[LAMP_RED] = 1'b1;
            CODE_AMBER:  l[LAMP_AMB] = 1'b1;
            CODE_GREEN:  l[LAMP_GRN] = 1'b1;
            CODE_FL_AMB: l[LAMP_AMB] = phase;
            CODE_FL_RED: l[LAMP_RED] = phase;
            default:     l[LAMP_RED] = 1'b1;
        endcase
        return l;
    endfunction

    function automatic logic is_go(input logic [2:0] code);
        return (code == CODE_AMBER) ||
               (code == CODE_GREEN) ||
               (code == CODE_FL_AMB);
    endfunction

endpackage

// File: rtl/intersection_lamp_driver_if.sv
// Command word in, lamp drives and status out, between the
// gpio_0 port (master) and the lamp driver (slave).
interface intersection_lamp_driver_if;
    logic [15:0] cmd;
    logic [11:0] lamp;
    logic        fault;
    logic [1:0]  fault_code;
    logic [1:0]  state;

    modport master (
        output cmd,
        input  lamp,
        input  fault,
        input  fault_code,
        input  state
    );

    modport slave (
        input  cmd,
        output lamp,
        output fault,
        output fault_code,
        output state
    );
endinterface

// File: rtl/lamp_flash_timer.sv
// Free-running half-period counter; phase starts lit and
// toggles each time the counter wraps.
module lamp_flash_timer #(
    parameter int unsigned FLASH_HALF = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic phase_o
);

    localparam int unsigned CW =
        (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          phase_q;
    logic          wrap;

    assign wrap  = (cnt_q == CW'(FLASH_HALF - 1));
    assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            if (wrap) begin
                phase_q <= ~phase_q;
            end
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/intersection_lamp_driver.sv
// Decodes the gpio_0 lamp command into R/A/G drives with a startup
// all-red hold, heartbeat watchdog and conflicting-green interlock.
module intersection_lamp_driver
    import intersection_pkg::*;
#(
    parameter int unsigned FLASH_HALF     = 25_000_000,
    parameter int unsigned WDOG_CYCLES    = 50_000_000,
    parameter int unsigned STARTUP_CYCLES = 100_000_000
) (
    input logic                        clock,
    input logic                        reset,
    intersection_lamp_driver_if.slave  bus
);

    localparam int unsigned STW =
        (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int unsigned WDW =
        (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [15:0]    cmd_q;
    logic           hb_q;
    logic [STW-1:0] st_cnt_q;
    logic [WDW-1:0] wd_cnt_q;
    state_e         state_q;
    logic [11:0]    lamp_q;
    logic           fault_q;
    logic [1:0]     fault_code_q;

    logic           phase;
    logic [11:0]    lamp_d;
    logic [11:0]    fs_lamp;
    logic [1:0]     fault_code_d;
    logic           ns_go;
    logic           ew_go;
    logic           conflict;
    logic           toggle;
    logic           wd_exp;
    logic           st_done;
    logic           enable;
    logic           unused_cmd;

    lamp_flash_timer #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flash (
        .clock   (clock),
        .reset   (reset),
        .phase_o (phase)
    );

    always_comb begin
        lamp_d = '0;
        for (int i = 0; i < 4; i++) begin
            lamp_d[3*i +: 3] = decode_code(cmd_q[3*i +: 3], phase);
        end
    end

    // Approaches 0/2 (N/S) against 1/3 (E/W).
    assign ns_go    = is_go(cmd_q[2:0]) | is_go(cmd_q[8:6]);
    assign ew_go    = is_go(cmd_q[5:3]) | is_go(cmd_q[11:9]);
    assign conflict = ns_go & ew_go;

    assign enable   = cmd_q[14];
    assign toggle   = cmd_q[15] ^ hb_q;
    assign wd_exp   = !toggle &&
                      (wd_cnt_q == WDW'(WDOG_CYCLES - 1));
    assign st_done  = (st_cnt_q == STW'(STARTUP_CYCLES - 1));
    assign fs_lamp  = phase ? ALL_AMBER : 12'h000;

    assign fault_code_d = (wd_exp && conflict) ? FC_BOTH :
                          conflict             ? FC_CONFLICT :
                                                 FC_WDOG;

    assign unused_cmd = ^cmd_q[13:12];

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q        <= '0;
            hb_q         <= 1'b0;
            st_cnt_q     <= '0;
            wd_cnt_q     <= '0;
            state_q      <= ST_STARTUP;
            lamp_q       <= ALL_RED;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            cmd_q <= bus.cmd;
            hb_q  <= cmd_q[15];
            unique case (state_q)
                ST_STARTUP: begin
                    lamp_q <= ALL_RED;
                    if (st_done && enable) begin
                        state_q  <= ST_RUN;
                        wd_cnt_q <= '0;
                    end else if (!st_done) begin
                        st_cnt_q <= st_cnt_q + STW'(1);
                    end
                end
                ST_RUN: begin
                    if (wd_exp || conflict) begin
                        state_q      <= ST_FAILSAFE;
                        lamp_q       <= fs_lamp;
                        fault_q      <= 1'b1;
                        fault_code_q <= fault_code_d;
                    end else if (!enable) begin
                        state_q  <= ST_STARTUP;
                        st_cnt_q <= '0;
                        lamp_q   <= ALL_RED;
                    end else begin
                        lamp_q   <= lamp_d;
                        wd_cnt_q <= toggle ? '0 : wd_cnt_q + WDW'(1);
                    end
                end
                ST_FAILSAFE: begin
                    if (!enable) begin
                        state_q      <= ST_STARTUP;
                        st_cnt_q     <= '0;
                        lamp_q       <= ALL_RED;
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                    end else begin
                        lamp_q <= fs_lamp;
                    end
                end
                default: begin
                    state_q  <= ST_STARTUP;
                    st_cnt_q <= '0;
                    lamp_q   <= ALL_RED;
                end
            endcase
        end
    end

    assign bus.lamp       = lamp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_intersection_lamp_driver.sv
// Directed bench for intersection_lamp_driver with short timers
// (FLASH_HALF=4, WDOG_CYCLES=20, STARTUP_CYCLES=8).
module tb_intersection_lamp_driver;

    localparam int FH = 4;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   ne;

    intersection_lamp_driver_if bus ();

    intersection_lamp_driver #(
        .FLASH_HALF     (FH),
        .WDOG_CYCLES    (20),
        .STARTUP_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            ne++;
        end
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [15:0] obs,
        input logic [15:0] exp
    );
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lamp after edge k shows the flash phase held before that edge.
    function automatic logic [11:0] flash_exp(
        input int          k,
        input logic [11:0] pat
    );
        return (((k - 1) / FH) % 2 == 0) ? pat : 12'h000;
    endfunction

    initial begin
        tests   = 0;
        fails   = 0;
        ne      = 0;
        reset   = 1'b1;
        bus.cmd = 16'h42CB;
        step(2);
        chk("rst_lamp", bus.lamp, 12'h924);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_code", bus.fault_code, 2'b00);
        chk("rst_state", bus.state, 2'b00);
        reset = 1'b0;
        ne    = 0;

        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("t1_startup_red", bus.lamp, 12'h924);
            if (i == 7) chk("t1_pre_run", bus.state, 2'b00);
        end
        chk("t1_state_run", bus.state, 2'b01);
        step(1);
        chk("t1_lamp", bus.lamp, 12'h861);

        for (int i = 0; i < 20; i++) begin
            bus.cmd[15] = ~bus.cmd[15];
            step(10);
        end
        chk("t2_alive_state", bus.state, 2'b01);
        chk("t2_alive_fault", bus.fault, 1'b0);
        step(11);
        chk("t2_pre_expiry", bus.state, 2'b01);
        step(1);
        chk("t2_fs_state", bus.state, 2'b10);
        chk("t2_fs_fault", bus.fault, 1'b1);
        chk("t2_fs_code", bus.fault_code, 2'b01);
        chk("t2_fs_lamp", bus.lamp, flash_exp(ne, 12'h492));
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("t2_flash", bus.lamp, flash_exp(ne, 12'h492));
        end

        bus.cmd[14] = 1'b0;
        step(2);
        chk("t4_state", bus.state, 2'b00);
        chk("t4_fault", bus.fault, 1'b0);
        chk("t4_code", bus.fault_code, 2'b00);
        chk("t4_lamp", bus.lamp, 12'h924);
        bus.cmd[14] = 1'b1;
        step(7);
        chk("t4_still_startup", bus.state, 2'b00);
        step(1);
        chk("t4_run", bus.state, 2'b01);
        step(1);
        chk("t4_lamp_run", bus.lamp, 12'h861);

        bus.cmd[5:3] = 3'b011;
        step(1);
        chk("t3_old_lamp", bus.lamp, 12'h861);
        chk("t3_old_state", bus.state, 2'b01);
        step(1);
        chk("t3_state", bus.state, 2'b10);
        chk("t3_code", bus.fault_code, 2'b10);
        chk("t3_fault", bus.fault, 1'b1);
        chk("t3_lamp", bus.lamp, flash_exp(ne, 12'h492));
        chk("t3_no_green", bus.lamp & 12'h249, 12'h000);

        step(3);
        chk("t6_pre_state", bus.state, 2'b10);
        reset   = 1'b1;
        bus.cmd = 16'h42CB;
        step(1);
        reset = 1'b0;
        ne    = 0;
        chk("t6_lamp", bus.lamp, 12'h924);
        chk("t6_fault", bus.fault, 1'b0);
        chk("t6_state", bus.state, 2'b00);
        chk("t6_code", bus.fault_code, 2'b00);

        step(8);
        chk("t5_run", bus.state, 2'b01);
        step(18);
        bus.cmd = 16'h42DB;
        step(1);
        chk("t5_pre_state", bus.state, 2'b01);
        step(1);
        chk("t5_state", bus.state, 2'b10);
        chk("t5_code", bus.fault_code, 2'b11);
        chk("t5_fault", bus.fault, 1'b1);
        chk("t5_lamp", bus.lamp, flash_exp(ne, 12'h492));

        bus.cmd = 16'h0FBE;
        step(2);
        chk("t7_exit_state", bus.state, 2'b00);
        chk("t7_exit_fault", bus.fault, 1'b0);
        chk("t7_exit_code", bus.fault_code, 2'b00);
        bus.cmd = 16'h4FBE;
        step(8);
        chk("t7_run", bus.state, 2'b01);
        step(1);
        chk("t7_code67_red", bus.lamp, 12'h924);
        chk("t7_code67_fault", bus.fault, 1'b0);
        bus.cmd = 16'h4B6D;
        step(1);
        chk("t7_red_hold", bus.lamp, 12'h924);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("t7_red_flash", bus.lamp, flash_exp(ne, 12'h924));
        end
        chk("t7_end_state", bus.state, 2'b01);
        chk("t7_end_fault", bus.fault, 1'b0);
        chk("t7_end_code", bus.fault_code, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
